// File: rtl/sdm_pkg.sv
// Shared constants and width helpers for the 1-bit sigma-delta CIC path.
package sdm_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int cic_acc_w(input int order, input int r_log2);
        return order * r_log2 + 1;
    endfunction

    function automatic int cic_shift(input int order, input int r_log2, input int w);
        return order * r_log2 - w;
    endfunction

endpackage

// File: rtl/cic_int3.sv
// Three cascaded integrators for the sinc^3 decimator; modular wrap is intentional.
module cic_int3 #(
    parameter int ACC_W = 19
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [ACC_W-1:0] i3
);

    logic [ACC_W-1:0] i1;
    logic [ACC_W-1:0] i2;

    // All stages advance together from their old values.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else if (en) begin
            i1 <= i1 + {{(ACC_W-1){1'b0}}, din};
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

endmodule

// File: rtl/sdm1b_cic_dec.sv
// Third-order CIC decimator: 1-bit unipolar sigma-delta stream in, W-bit saturated PCM out.
// Integrators live in cic_int3; decimation count, comb, clipping and settle tracking live here.
module sdm1b_cic_dec
    import sdm_pkg::*;
#(
    parameter int W      = 12,
    parameter int R_LOG2 = 6
) (
    input  logic         clk_fast,
    input  logic         rst,
    input  logic         din_en,
    input  logic         din,
    // dout_valid is a one-cycle qualifier with no back-pressure: dout is new on that
    // cycle and holds until the next pulse, so a consumer must take it when it sees it.
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         dout_settled,
    output logic         sat
);

    localparam int ACC_W = cic_acc_w(CIC_ORDER, R_LOG2);
    localparam int SHIFT = cic_shift(CIC_ORDER, R_LOG2, W);
    localparam int Q_W   = ACC_W - SHIFT;
    localparam logic [2:0] SETTLE_MAX = 3'd7;

    if (CIC_ORDER * R_LOG2 < W) begin : g_bad_params
        $error("sdm1b_cic_dec: CIC_ORDER*R_LOG2 must be >= W");
    end

    logic [R_LOG2-1:0] dcnt;
    logic              dec_evt;
    logic [ACC_W-1:0]  i3;
    logic [ACC_W-1:0]  z1;
    logic [ACC_W-1:0]  z2;
    logic [ACC_W-1:0]  z3;
    logic [ACC_W-1:0]  c1;
    logic [ACC_W-1:0]  c2;
    logic [ACC_W-1:0]  c3;
    logic [Q_W-1:0]    q;
    logic              clip;
    logic [2:0]        settle_cnt;

    cic_int3 #(
        .ACC_W(ACC_W)
    ) u_int3 (
        .clk_fast(clk_fast),
        .rst     (rst),
        .en      (din_en),
        .din     (din),
        .i3      (i3)
    );

    assign dec_evt = din_en && (&dcnt);

    // Comb differences use the pre-update i3; modular arithmetic recovers the true value.
    assign c1 = i3 - z1;
    assign c2 = c1 - z2;
    assign c3 = c2 - z3;

    // Only full scale (c3 = R^3) reaches bit W after truncation.
    assign q    = Q_W'(c3 >> SHIFT);
    assign clip = q[W];

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            dcnt       <= '0;
            z1         <= '0;
            z2         <= '0;
            z3         <= '0;
            dout       <= '0;
            sat        <= 1'b0;
            dout_valid <= 1'b0;
            settle_cnt <= '0;
        end else begin
            dout_valid <= dec_evt;
            if (din_en) begin
                dcnt <= dcnt + 1'b1;
            end
            if (dec_evt) begin
                z1   <= i3;
                z2   <= c1;
                z3   <= c2;
                dout <= clip ? '1 : q[W-1:0];
                sat  <= clip;
                if (settle_cnt != SETTLE_MAX) begin
                    settle_cnt <= settle_cnt + 3'd1;
                end
            end
        end
    end

    // Three comb delays need three frames of history; the fourth output is the first clean one.
    assign dout_settled = settle_cnt[2];

endmodule

// File: tb/tb_sdm1b_cic_dec.sv
// Bench for sdm1b_cic_dec: directed vectors against a sinc^3 impulse-response model.
module tb_sdm1b_cic_dec;

    localparam int W     = 12;
    localparam int RL    = 6;
    localparam int R     = 64;
    localparam int SHIFT = 3 * RL - W;
    localparam longint FS = 4095;

    logic         clk_fast = 1'b0;
    logic         rst = 1'b1;
    logic         din_en = 1'b0;
    logic         din = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_settled;
    logic         sat;

    sdm1b_cic_dec #(.W(W), .R_LOG2(RL)) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .din_en      (din_en),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_settled(dout_settled),
        .sat         (sat)
    );

    always #5 clk_fast = ~clk_fast;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    int           hist[$];
    int           pulses = 0;
    logic [W-1:0] exp_dout = '0;
    logic         exp_sat = 1'b0;
    logic         exp_valid = 1'b0;
    logic         exp_settled = 1'b0;
    logic         exp_coll = 1'b0;
    int           coll_lo = 0;
    int           coll_hi = -1;
    longint       coll_sum = 0;
    int           coll_n = 0;

    int last_pulse_cyc  = -1;
    int last_period     = 0;
    int rel_cyc         = 0;
    int first_after_rel = -1;
    bit armed           = 1'b0;
    bit pending_release = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic longint cb2(input longint m);
        return (m < 2) ? 64'sd0 : m * (m - 1) / 2;
    endfunction

    // Impulse response of three cascaded length-R moving sums, seen at the frame edge.
    function automatic longint h3(input longint k);
        return cb2(k) - 3 * cb2(k - R) + 3 * cb2(k - 2 * R) - cb2(k - 3 * R);
    endfunction

    // Apply one cycle of inputs and predict the outputs after the next rising edge.
    task automatic drive(input logic en, input logic d);
        longint c3;
        longint q;
        int     n;
        int     j0;
        @(negedge clk_fast);
        if (pending_release) begin
            rst = 1'b0;
            rel_cyc = cyc;
            armed = 1'b1;
            pending_release = 1'b0;
        end
        din_en = en;
        din = d;
        exp_valid = 1'b0;
        exp_coll = 1'b0;
        if (en) begin
            n = hist.size();
            if ((n % R) == R - 1) begin
                c3 = 0;
                j0 = (n - 3 * R > 0) ? n - 3 * R : 0;
                for (int j = j0; j < n; j++) begin
                    c3 += longint'(hist[j]) * h3(longint'(n - 1 - j));
                end
                q = c3 >>> SHIFT;
                exp_dout = (q > FS) ? W'(FS) : W'(q);
                exp_sat = (q > FS);
                exp_valid = 1'b1;
                pulses++;
                exp_settled = (pulses >= 4);
                exp_coll = (pulses >= coll_lo) && (pulses <= coll_hi);
            end
            hist.push_back(int'(d));
        end
    endtask

    task automatic reset_dut();
        drive(1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_valid", 64'(dout_valid), 64'(0));
        chk("rst_settled", 64'(dout_settled), 64'(0));
        chk("rst_sat", 64'(sat), 64'(0));
        hist.delete();
        pulses = 0;
        exp_dout = '0;
        exp_sat = 1'b0;
        exp_valid = 1'b0;
        exp_settled = 1'b0;
        exp_coll = 1'b0;
        pending_release = 1'b1;
    endtask

    task automatic run_loop(input int dval, input int nframes);
        int   acc;
        logic b;
        reset_dut();
        acc = 0;
        coll_lo = 5;
        coll_hi = 4 + nframes;
        coll_sum = 0;
        coll_n = 0;
        for (int i = 0; i < (4 + nframes) * R; i++) begin
            acc += dval;
            b = (acc >= 4096);
            if (b) acc -= 4096;
            drive(1'b1, b);
        end
        drive(1'b0, 1'b0);
        coll_hi = -1;
        chk($sformatf("loop%0d_frames", dval), 64'(coll_n), 64'(nframes));
        chk_rng($sformatf("loop%0d_mean_sum", dval), coll_sum,
                longint'(dval - 2) * nframes, longint'(dval + 2) * nframes);
    endtask

    // compare process: every cycle, DUT against the model
    initial begin
        forever begin
            @(posedge clk_fast);
            #1;
            cyc++;
            chk("dout_valid", 64'(dout_valid), 64'(exp_valid));
            chk("dout", 64'(dout), 64'(exp_dout));
            chk("sat", 64'(sat), 64'(exp_sat));
            chk("dout_settled", 64'(dout_settled), 64'(exp_settled));
            if (dout_valid === 1'b1) begin
                if (last_pulse_cyc >= 0) last_period = cyc - last_pulse_cyc;
                last_pulse_cyc = cyc;
                if (armed) begin
                    first_after_rel = cyc - rel_cyc;
                    armed = 1'b0;
                end
            end
            if (exp_coll) begin
                coll_sum += longint'(dout);
                coll_n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint gsum;
        longint first_ones;
        gsum = 0;
        first_ones = 0;
        for (int k = 0; k < 4 * R; k++) gsum += h3(longint'(k));
        for (int k = 0; k < R - 1; k++) first_ones += h3(longint'(k));
        chk("model_gain", 64'(gsum), 64'(262144));
        chk("model_h2", 64'(h3(2)), 64'(1));
        chk("model_first_ones", 64'(first_ones), 64'(39711));

        // 1: all zeros
        reset_dut();
        for (int i = 0; i < 8 * R; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        chk("t1_dout", 64'(dout), 64'(0));
        chk("t1_sat", 64'(sat), 64'(0));
        chk("t1_settled", 64'(dout_settled), 64'(1));
        chk("t1_period", 64'(last_period), 64'(64));

        // 2: all ones
        for (int i = 0; i < 8 * R; i++) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        chk("t2_dout", 64'(dout), 64'(4095));
        chk("t2_sat", 64'(sat), 64'(1));

        // 3: alternating
        for (int i = 0; i < 8 * R; i++) drive(1'b1, logic'(i % 2 == 0));
        drive(1'b0, 1'b0);
        chk("t3_dout", 64'(dout), 64'(2048));
        chk("t3_sat", 64'(sat), 64'(0));

        // 4: loopback from a first-order modulator
        run_loop(1000, 8);
        run_loop(3071, 64);

        // 5: enable 1,0,0 with din ignored while disabled
        reset_dut();
        for (int i = 0; i < 8 * 3 * R; i++) begin
            if (i % 3 == 0) drive(1'b1, 1'b1);
            else drive(1'b0, logic'($urandom_range(0, 1)));
        end
        drive(1'b0, 1'b0);
        chk("t5_period", 64'(last_period), 64'(192));
        chk("t5_dout", 64'(dout), 64'(4095));
        chk("t5_sat", 64'(sat), 64'(1));

        // 6: reset mid-frame
        reset_dut();
        for (int i = 0; i < 8 * R + 30; i++) drive(1'b1, logic'(i % 2 == 0));
        reset_dut();
        first_after_rel = -1;
        for (int i = 0; i < 4 * R - 1; i++) drive(1'b1, logic'(i % 2 == 0));
        @(posedge clk_fast);
        #2;
        chk("t6_rel_latency", 64'(first_after_rel), 64'(64));
        chk("t6_settled_pre", 64'(dout_settled), 64'(0));
        drive(1'b1, 1'b1);
        @(posedge clk_fast);
        #2;
        chk("t6_valid_4th", 64'(dout_valid), 64'(1));
        chk("t6_settled_4th", 64'(dout_settled), 64'(1));
        for (int i = 0; i < 2 * R; i++) drive(1'b1, logic'(i % 2 == 0));
        drive(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdm1b_cic_dec.md
Name: sdm1b_cic_dec

Overview:
- Third-order CIC (sinc^3) decimator that turns a 1-bit sigma-delta bitstream back into W-bit unsigned PCM.
- It is the receive end of the 1-bit modulator path. It is used to loop back and check the modulator, and to demodulate external 1-bit streams in the clk_fast domain.
- Input bit density d maps to output ≈ d·2^W. A modulator fed a constant D decodes to ≈ D.

Parameters:
- W, 12, output PCM width.
- R_LOG2, 6, log2 of the decimation ratio R (R = 64). Legal only when 3·R_LOG2 ≥ W.
- Derived localparams (not overridable):
  - ACC_W = 3·R_LOG2 + 1, internal width.
  - SHIFT = 3·R_LOG2 − W, output truncation.

Ports:
- clk_fast  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- din_en  in  1  sample strobe; din is consumed only on cycles where din_en = 1.
- din  in  1  bitstream; 1 → +1, 0 → 0 (unipolar).
- dout  out  W  decimated PCM, unsigned, saturated.
- dout_valid  out  1  one-cycle pulse when dout updates.
- dout_settled  out  1  high once the filter history is fully populated.
- sat  out  1  high while the current dout is a clipped value.

Behaviour:
- Reset (async assert, sync release): integrators, comb delays, decimation counter and settle counter clear to 0. dout = 0, dout_valid = 0, dout_settled = 0, sat = 0.
- Reset asserted mid-frame discards the partial frame. The first post-reset output comes R samples after reset release.
- Integrators, ACC_W bits, modular two's-complement wrap (wrap is intended; no overflow detection). On each clk_fast edge with din_en = 1, all three update in parallel from old values:
  - i1 ← i1 + din
  - i2 ← i2 + i1
  - i3 ← i3 + i2
- Integrators hold when din_en = 0.
- Decimation counter dcnt, R_LOG2 bits:
  - Increments on din_en and wraps R−1 → 0.
  - A decimation event occurs when din_en = 1 and dcnt = R−1.
- Comb path on a decimation event (combinational, ACC_W bits, modular):
  - c1 = i3 − z1
  - c2 = c1 − z2
  - c3 = c2 − z3
  - At the same edge: z1 ← i3, z2 ← c1, z3 ← c2 (i3 is the pre-update register value).
- Output register, at the same edge as the comb update:
  - dout ← min(c3 >> SHIFT, 2^W − 1).
  - sat ← 1 if clipped, else 0.
  - dout_valid = 1 for exactly that cycle.
  - dout holds between events.
- Latency: dout is registered one clk_fast edge after the R-th accepted sample of the frame.
- Gain: full-scale all-ones input gives c3 = R^3 = 2^(ACC_W−1), which clips to 2^W − 1 with sat = 1. Every other density is exact after truncation.
- Settling: a saturating 3-bit counter counts valid pulses. dout_settled rises together with the 4th dout_valid after reset and stays high until reset. Earlier outputs are transient and may be any value.
- din_en low for arbitrary gaps: state holds and output timing stretches. There is no requirement on din_en duty.
- din is ignored entirely when din_en = 0.

Decomposition:
- Shared package sdm_pkg:
  - CIC_ORDER = 3.
  - Function cic_acc_w(order, r_log2) returning ACC_W.
  - Function cic_shift(order, r_log2, w).
- One sub-module cic_int3: the three-stage integrator chain with enable, parameterised on ACC_W, async active-high reset.
- The top level holds dcnt, comb, saturation, valid and settle logic.

Test Plan:
1. Reset, then din = 0 with din_en = 1 constant for 8·R cycles. Required: dout = 0 on every valid pulse, pulse period exactly 64 cycles, sat = 0, dout_settled high from the 4th pulse.
2. din = 1 constant for 8·R cycles. Required: from pulse 5 on, dout = 4095 and sat = 1.
3. din alternating 1,0,1,0… for 8·R cycles. Required: from pulse 5 on, dout = 2048 and sat = 0.
4. Loopback with the 1-bit modulator (W = 12, dither off) driven by constant 1000, dout → din, din_en = 1. Required: settled outputs within 1000 ± 2. Repeat at 3071.
5. din_en pattern 1,0,0 repeating with din = 1. Required: valid pulse period 192 cycles, state unchanged on disabled cycles, settled value 4095.
6. Assert rst for 1 cycle midway through a frame. Required: all outputs 0 immediately (async). The next dout_valid occurs exactly 64 accepted samples after release, and dout_settled re-rises on the 4th pulse after release.
